// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - multi-port integer register file with write bypass and busy scoreboard
module regfile_mp_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*AW-1:0]    rs_addr,
    output logic [NREAD*XLEN-1:0]  rs_data,
    output logic [NREAD-1:0]       rs_busy,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr,
    input  logic                   flush,
    output logic [NUM_REGS-1:0]    busy_vec
);

    logic [XLEN-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_next;

    function automatic logic wr_match(input logic [AW-1:0] a);
        logic m;
        m = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) m = 1'b1;
        end
        return m;
    endfunction

    // Walking ports in ascending order lets the highest-index write win.
    function automatic logic [XLEN-1:0] wr_value(input logic [AW-1:0] a, input logic [XLEN-1:0] dflt);
        logic [XLEN-1:0] v;
        v = dflt;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*XLEN +: XLEN];
        end
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] val;
        logic            hit;

        assign a = rs_addr[i*AW +: AW];

        always_comb begin
            val = regs[a];
            hit = 1'b0;
            if (BYPASS != 0) begin
                hit = wr_match(a);
                val = wr_value(a, regs[a]);
            end
        end

        // x0 is hardwired: zero data and never busy, whatever is in flight.
        assign rs_data[i*XLEN +: XLEN] = (a == '0) ? '0 : val;
        assign rs_busy[i] = (a != '0) && busy_vec[a] && !hit;
    end

    // Alloc beats a same-cycle writeback: the alloc belongs to a newer producer.
    always_comb begin
        busy_next    = busy_vec;
        busy_next[0] = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (flush)
                busy_next[r] = 1'b0;
            else if (alloc_en && alloc_addr == AW'(r))
                busy_next[r] = 1'b1;
            else if (wr_match(AW'(r)))
                busy_next[r] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_vec <= '0;
        else        busy_vec <= busy_next;
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb/tb_regfile_mp_scoreboard.sv - directed table-driven bench for regfile_mp_scoreboard
module tb_regfile_mp_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data, rs_data_nb;
    logic [1:0]  rs_busy, rs_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic [31:0] busy_vec, busy_vec_nb;

    int tests = 0;
    int fails = 0;

    regfile_mp_scoreboard #(.NREAD(2), .NWRITE(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec)
    );

    regfile_mp_scoreboard #(.NREAD(2), .NWRITE(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data_nb), .rs_busy(rs_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        al;
        logic [4:0]  aa;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  bz;
        logic [31:0] nd0;
        logic [1:0]  nbz;
        logic [31:0] vec;
    } vec_t;

    vec_t tv [16];

    function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                                logic [4:0] wa1, logic [31:0] wd1, logic al, logic [4:0] aa,
                                logic fl, logic [4:0] ra0, logic [4:0] ra1,
                                logic [31:0] d0, logic [31:0] d1, logic [1:0] bz,
                                logic [31:0] nd0, logic [1:0] nbz, logic [31:0] vec);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.al = al; v.aa = aa; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
        v.d0 = d0; v.d1 = d1; v.bz = bz; v.nd0 = nd0; v.nbz = nbz; v.vec = vec;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0; rs_addr = '0;
    endtask

    initial begin
        //      we    wa0 wd0           wa1 wd1     al  aa fl ra0 ra1 d0            d1            bz     nd0           nbz    vec
        tv[0]  = mk(2'b01, 7, 32'hA5A5A5A5, 0, 0,     0, 0, 0, 7, 7,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h0,        2'b00, 32'h0);
        tv[1]  = mk(2'b00, 0, 0,            0, 0,     0, 0, 0, 7, 0,  32'hA5A5A5A5, 32'h0,        2'b00, 32'hA5A5A5A5, 2'b00, 32'h0);
        tv[2]  = mk(2'b11, 3, 32'h11,       3, 32'h22,0, 0, 0, 3, 3,  32'h22,       32'h22,       2'b00, 32'h0,        2'b00, 32'h0);
        tv[3]  = mk(2'b00, 0, 0,            0, 0,     0, 0, 0, 3, 7,  32'h22,       32'hA5A5A5A5, 2'b00, 32'h22,       2'b00, 32'h0);
        tv[4]  = mk(2'b01, 0, 32'h1234,     0, 0,     1, 0, 0, 0, 0,  32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 32'h0);
        tv[5]  = mk(2'b00, 0, 0,            0, 0,     1, 9, 0, 9, 0,  32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 32'h200);
        tv[6]  = mk(2'b00, 0, 0,            0, 0,     0, 0, 0, 9, 9,  32'h0,        32'h0,        2'b11, 32'h0,        2'b11, 32'h200);
        tv[7]  = mk(2'b00, 0, 0,            0, 0,     0, 0, 0, 9, 9,  32'h0,        32'h0,        2'b11, 32'h0,        2'b11, 32'h200);
        tv[8]  = mk(2'b01, 9, 32'h99,       0, 0,     0, 0, 0, 9, 3,  32'h99,       32'h22,       2'b00, 32'h0,        2'b01, 32'h0);
        tv[9]  = mk(2'b10, 0, 0,            9, 32'h100,1,9, 0, 9, 9,  32'h100,      32'h100,      2'b00, 32'h99,       2'b00, 32'h200);
        tv[10] = mk(2'b00, 0, 0,            0, 0,     0, 0, 0, 9, 9,  32'h100,      32'h100,      2'b11, 32'h100,      2'b11, 32'h200);
        tv[11] = mk(2'b00, 0, 0,            0, 0,     1, 1, 0, 1, 9,  32'h0,        32'h100,      2'b10, 32'h0,        2'b10, 32'h202);
        tv[12] = mk(2'b00, 0, 0,            0, 0,     1, 2, 0, 1, 2,  32'h0,        32'h0,        2'b01, 32'h0,        2'b01, 32'h206);
        tv[13] = mk(2'b00, 0, 0,            0, 0,     1, 31,0, 31,0,  32'h0,        32'h0,        2'b00, 32'h0,        2'b00, 32'h80000206);
        tv[14] = mk(2'b00, 0, 0,            0, 0,     1, 4, 1, 31,4,  32'h0,        32'h0,        2'b01, 32'h0,        2'b01, 32'h0);
        tv[15] = mk(2'b00, 0, 0,            0, 0,     0, 0, 0, 3, 9,  32'h22,       32'h100,      2'b00, 32'h22,       2'b00, 32'h0);

        rst_n = 1'b0;
        idle_inputs();
        rs_addr = {5'd9, 5'd7};
        #1;
        chk("reset_busy_vec", 64'(busy_vec), 64'h0);
        chk("reset_rs_data", rs_data, 64'h0);
        chk("reset_rs_busy", 64'(rs_busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            wr_en      = tv[k].we;
            wr_addr    = {tv[k].wa1, tv[k].wa0};
            wr_data    = {tv[k].wd1, tv[k].wd0};
            alloc_en   = tv[k].al;
            alloc_addr = tv[k].aa;
            flush      = tv[k].fl;
            rs_addr    = {tv[k].ra1, tv[k].ra0};
            #1;
            chk($sformatf("v%0d_rs_data0", k), 64'(rs_data[31:0]), 64'(tv[k].d0));
            chk($sformatf("v%0d_rs_data1", k), 64'(rs_data[63:32]), 64'(tv[k].d1));
            chk($sformatf("v%0d_rs_busy", k), 64'(rs_busy), 64'(tv[k].bz));
            chk($sformatf("v%0d_nb_rs_data0", k), 64'(rs_data_nb[31:0]), 64'(tv[k].nd0));
            chk($sformatf("v%0d_nb_rs_busy", k), 64'(rs_busy_nb), 64'(tv[k].nbz));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy_vec", k), 64'(busy_vec), 64'(tv[k].vec));
            chk($sformatf("v%0d_nb_busy_vec", k), 64'(busy_vec_nb), 64'(tv[k].vec));
        end

        // Mid-run asynchronous reset after populating x5 and marking it busy
        @(negedge clk);
        idle_inputs();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        @(negedge clk);
        idle_inputs();
        alloc_en = 1'b1; alloc_addr = 5'd5;
        @(negedge clk);
        idle_inputs();
        rs_addr = {5'd3, 5'd5};
        #1;
        chk("pre_reset_x5", 64'(rs_data[31:0]), 64'hDEADBEEF);
        chk("pre_reset_busy_vec", 64'(busy_vec), 64'h20);
        rst_n = 1'b0;
        #1;
        chk("async_reset_rs_data", rs_data, 64'h0);
        chk("async_reset_busy_vec", 64'(busy_vec), 64'h0);
        chk("async_reset_rs_busy", 64'(rs_busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_rs_data", rs_data, 64'h0);
        chk("post_reset_busy_vec", 64'(busy_vec), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
